// File: rtl/hack_pmem_pkg.sv
// Shared types and size helpers for the Hack program memory loader.
// Holds the loader FSM state encoding and the BPW / DEPTH derivations.
package hack_pmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_WORD,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic int calc_bpw(input int data_w);
    return data_w / 8;
  endfunction

  // 64-bit so the depth can be compared against any header length without overflow.
  function automatic longint calc_depth(input int addr_w);
    return longint'(1) << addr_w;
  endfunction

endpackage

// File: rtl/hack_pmem_ram.sv
// Synchronous-read instruction store: one write port (loader), one read port (CPU fetch).
// Written so synthesis can map it onto block RAM.
module hack_pmem_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array itself has no reset so it stays block-RAM mappable; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/hack_prog_mem_loader.sv
// Hack program memory with a byte-serial boot loader (length header, then MSB-first words).
// Define PMEM_CHECKSUM_EN to add a running checksum output of the words written by a load.
module hack_prog_mem_loader
  import hack_pmem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_valid,
  input  logic              load_start,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
`ifdef PMEM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int     BPW   = calc_bpw(DATA_W);
  localparam longint DEPTH = calc_depth(ADDR_W);
  localparam int     BC_W  = (BPW > 1) ? $clog2(BPW) : 1;

  state_t            state, state_next;
  logic [7:0]        len_hi;
  logic [15:0]       hdr_len;
  logic [LEN_W-1:0]  words_left;
  logic [ADDR_W-1:0] ptr;
  logic [BC_W-1:0]   byte_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] word_next;
  logic              accept;
  logic              word_last;
  logic              mem_we;
  logic              start_ok;
  logic              fetch_en;

  assign hdr_len   = {len_hi, ld_byte};
  assign word_next = (shreg << 8) | DATA_W'(ld_byte);
  assign accept    = ld_valid && ld_ready;
  assign word_last = (byte_cnt == BC_W'(BPW - 1));
  assign mem_we    = accept && (state == ST_WORD) && word_last;
  assign start_ok  = load_start && (state inside {ST_IDLE, ST_DONE, ST_ERR});
  assign fetch_en  = cpu_en && !load_busy;

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    ld_ready   = 1'b0;
    load_busy  = 1'b0;
    load_done  = 1'b0;
    load_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_start) state_next = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        ld_ready  = 1'b1;
        load_busy = 1'b1;
        if (ld_valid) state_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        ld_ready  = 1'b1;
        load_busy = 1'b1;
        if (ld_valid) begin
          if (hdr_len == 16'd0)                 state_next = ST_DONE;
          else if (longint'(hdr_len) > DEPTH)   state_next = ST_ERR;
          else                                  state_next = ST_WORD;
        end
      end
      ST_WORD: begin
        ld_ready  = 1'b1;
        load_busy = 1'b1;
        if (ld_valid && word_last && (words_left == LEN_W'(1))) state_next = ST_DONE;
      end
      ST_DONE: begin
        load_done = 1'b1;
        if (load_start) state_next = ST_LEN_HI;
      end
      ST_ERR: begin
        load_err = 1'b1;
        if (load_start) state_next = ST_LEN_HI;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Byte assembler, word counter and write pointer; a partial word simply waits for more bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi     <= '0;
      words_left <= '0;
      ptr        <= '0;
      byte_cnt   <= '0;
      shreg      <= '0;
    end else if (start_ok) begin
      ptr      <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (accept) begin
      case (state)
        ST_LEN_HI: len_hi     <= ld_byte;
        ST_LEN_LO: words_left <= LEN_W'(hdr_len);
        ST_WORD: begin
          shreg <= word_next;
          if (word_last) begin
            byte_cnt   <= '0;
            ptr        <= ptr + ADDR_W'(1);
            words_left <= words_left - LEN_W'(1);
          end else begin
            byte_cnt <= byte_cnt + BC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cpu_valid <= 1'b0;
    else        cpu_valid <= fetch_en;
  end

`ifdef PMEM_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      checksum <= '0;
    else if (start_ok) checksum <= '0;
    else if (mem_we)   checksum <= checksum + word_next;
  end
`endif

  hack_pmem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (ptr),
    .wdata (word_next),
    .re    (fetch_en),
    .raddr (cpu_addr),
    .rdata (cpu_data)
  );

endmodule
